// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch stage with a three-state request FSM.
//
// The fetch cycle runs IDLE -> FETCH -> HOLD -> FETCH. In FETCH the memory
// request is held at the current PC until IAck arrives. In HOLD the fetched
// word is presented downstream until the consumer accepts it (Stall=0). On
// accept the PC advances to the jump target, the branch target or PC+4, in
// that order of priority.
//
// Ports
//   Clk          in   1   rising-edge clock
//   Clrn         in   1   synchronous active-low reset
//   Stall        in   1   consumer not ready; hold the fetched instruction
//   Branch       in   1   take BranchTarget on next accept
//   BranchTarget in  32   branch destination
//   Jump         in   1   take JumpTarget on next accept (beats Branch)
//   JumpTarget   in  32   jump destination
//   IReq         out  1   instruction-memory request (registered)
//   IAddr        out 32   instruction-memory address (= PC)
//   IAck         in   1   memory response valid, IData valid same cycle
//   IData        in  32   instruction word from memory
//   Valid        out  1   Inst/Imm16/Se/PC4 hold a fetched instruction
//   Inst         out 32   fetched instruction register
//   Imm16        out 16   Inst[15:0], feeds the immediate extender
//   Se           out  1   1 = sign-extend, 0 = zero-extend (andi/ori/xori/lui)
//   PC4          out 32   address of the fetched instruction plus 4
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IData,
  output logic        Valid,
  output logic [31:0] Inst,
  output logic [15:0] Imm16,
  output logic        Se,
  output logic [31:0] PC4
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        ireq_q, ireq_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc;

  // Jump beats Branch beats sequential; only consumed at an accept edge.
  always_comb begin
    next_pc = pc4_q;
    if (Jump) begin
      next_pc = JumpTarget;
    end else if (Branch) begin
      next_pc = BranchTarget;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    ireq_d  = ireq_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        ireq_d  = 1'b1;
      end
      FETCH: begin
        if (IAck) begin
          inst_d  = IData;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          ireq_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!Stall) begin
          // Targets are word-aligned by clearing the low two bits.
          pc_d    = next_pc & ~32'd3;
          valid_d = 1'b0;
          ireq_d  = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        ireq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      inst_q  <= '0;
      ireq_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      ireq_q  <= ireq_d;
      valid_q <= valid_d;
    end
  end

  assign IReq  = ireq_q;
  assign IAddr = pc_q;
  assign Valid = valid_q;
  assign Inst  = inst_q;
  assign PC4   = pc4_q;
  assign Imm16 = inst_q[15:0];
  // Opcodes 6'h0C..6'h0F share the prefix 4'b0011 and zero-extend.
  assign Se    = (inst_q[31:28] != 4'b0011);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] idata;

  logic        iack0;
  logic        ireq0;
  logic [31:0] iaddr0;
  logic        valid0;
  logic [31:0] inst0;
  logic [15:0] imm16_0;
  logic        se0;
  logic [31:0] pc4_0;

  logic        iack1;
  logic        ireq1;
  logic [31:0] iaddr1;
  logic        valid1;
  logic [31:0] inst1;
  logic [15:0] imm16_1;
  logic        se1;
  logic [31:0] pc4_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut0 (
    .Clk(clk), .Clrn(clrn), .Stall(stall),
    .Branch(branch), .BranchTarget(branch_target),
    .Jump(jump), .JumpTarget(jump_target),
    .IReq(ireq0), .IAddr(iaddr0), .IAck(iack0), .IData(idata),
    .Valid(valid0), .Inst(inst0), .Imm16(imm16_0), .Se(se0), .PC4(pc4_0)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .Clk(clk), .Clrn(clrn), .Stall(stall),
    .Branch(branch), .BranchTarget(branch_target),
    .Jump(jump), .JumpTarget(jump_target),
    .IReq(ireq1), .IAddr(iaddr1), .IAck(iack1), .IData(idata),
    .Valid(valid1), .Inst(inst1), .Imm16(imm16_1), .Se(se1), .PC4(pc4_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fetched(input string tag, input logic [31:0] inst_e,
                               input logic [31:0] pc4_e, input logic se_e);
    check({tag, "_valid"}, {31'd0, valid0}, 32'd1);
    check({tag, "_inst"}, inst0, inst_e);
    check({tag, "_imm16"}, {16'd0, imm16_0}, {16'd0, inst_e[15:0]});
    check({tag, "_se"}, {31'd0, se0}, {31'd0, se_e});
    check({tag, "_pc4"}, pc4_0, pc4_e);
    check({tag, "_ireq"}, {31'd0, ireq0}, 32'd0);
  endtask

  initial begin
    clrn = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0; idata = '0;
    iack0 = 1'b0; iack1 = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ireq", {31'd0, ireq0}, 32'd0);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_inst", inst0, 32'd0);
    check("rst_pc4", pc4_0, 32'd0);
    check("rst_iaddr", iaddr0, 32'd0);
    check("rst_imm16", {16'd0, imm16_0}, 32'd0);
    check("rst_se", {31'd0, se0}, 32'd1);
    check("rst1_iaddr", iaddr1, 32'hFFFF_FFFC);
    check("rst1_ireq", {31'd0, ireq1}, 32'd0);

    // First request one cycle after release
    clrn = 1'b1;
    tick();
    check("first_ireq", {31'd0, ireq0}, 32'd1);
    check("first_iaddr", iaddr0, 32'd0);
    check("first1_iaddr", iaddr1, 32'hFFFF_FFFC);

    // Immediate ack
    iack0 = 1'b1; idata = 32'h2008_FFFF;
    tick();
    check_fetched("f0", 32'h2008_FFFF, 32'h0000_0004, 1'b1);
    check("f0_iaddr", iaddr0, 32'd0);

    // HOLD stalled: IAck, Branch and Jump all ignored
    stall = 1'b1; iack0 = 1'b1; idata = 32'hDEAD_BEEF;
    branch = 1'b1; branch_target = 32'h0000_0080;
    jump = 1'b1; jump_target = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetched("stall_a", 32'h2008_FFFF, 32'h0000_0004, 1'b1);
    end

    // Sequential accept
    stall = 1'b0; iack0 = 1'b0; branch = 1'b0; jump = 1'b0;
    tick();
    check("acc0_iaddr", iaddr0, 32'h0000_0004);
    check("acc0_ireq", {31'd0, ireq0}, 32'd1);
    check("acc0_valid", {31'd0, valid0}, 32'd0);

    // Delayed ack; Branch pulsed during FETCH is ignored
    branch = 1'b1; branch_target = 32'h0000_0080;
    for (int i = 0; i < 3; i++) begin
      tick();
      branch = 1'b0;
      check("wait_ireq", {31'd0, ireq0}, 32'd1);
      check("wait_iaddr", iaddr0, 32'h0000_0004);
      check("wait_valid", {31'd0, valid0}, 32'd0);
    end
    iack0 = 1'b1; idata = 32'h3508_8000;
    tick();
    check_fetched("ori", 32'h3508_8000, 32'h0000_0008, 1'b0);

    // Five stall cycles
    iack0 = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_fetched("stall_b", 32'h3508_8000, 32'h0000_0008, 1'b0);
      check("stall_b_iaddr", iaddr0, 32'h0000_0004);
    end
    stall = 1'b0;
    tick();
    check("acc1_iaddr", iaddr0, 32'h0000_0008);

    // Jump beats Branch, low bits cleared
    iack0 = 1'b1; idata = 32'h0C00_0010;
    tick();
    check_fetched("jal", 32'h0C00_0010, 32'h0000_000C, 1'b1);
    iack0 = 1'b0;
    branch = 1'b1; branch_target = 32'h0000_0042;
    jump = 1'b1; jump_target = 32'h0000_0101;
    tick();
    check("jump_iaddr", iaddr0, 32'h0000_0100);
    check("jump_ireq", {31'd0, ireq0}, 32'd1);
    branch = 1'b0; jump = 1'b0;

    // Branch only, low bits cleared
    iack0 = 1'b1; idata = 32'h3C01_1234;
    tick();
    check_fetched("lui", 32'h3C01_1234, 32'h0000_0104, 1'b0);
    iack0 = 1'b0;
    branch = 1'b1; branch_target = 32'h0000_0043;
    tick();
    check("br_iaddr", iaddr0, 32'h0000_0040);
    branch = 1'b0;

    // Reset on the same edge as IAck
    clrn = 1'b0; iack0 = 1'b1; idata = 32'h1234_5678;
    tick();
    check("rack_valid", {31'd0, valid0}, 32'd0);
    check("rack_ireq", {31'd0, ireq0}, 32'd0);
    check("rack_inst", inst0, 32'd0);
    check("rack_pc4", pc4_0, 32'd0);
    check("rack_iaddr", iaddr0, 32'd0);
    clrn = 1'b1; iack0 = 1'b0;
    tick();
    check("rreq_ireq", {31'd0, ireq0}, 32'd1);
    check("rreq_iaddr", iaddr0, 32'd0);
    check("rreq_valid", {31'd0, valid0}, 32'd0);

    // PC+4 wrap with RESET_PC = FFFF_FFFC
    check("wrap_req_iaddr", iaddr1, 32'hFFFF_FFFC);
    iack1 = 1'b1; idata = 32'h2008_FFFF;
    tick();
    check("wrap_valid", {31'd0, valid1}, 32'd1);
    check("wrap_pc4", pc4_1, 32'h0000_0000);
    check("wrap_inst", inst1, 32'h2008_FFFF);
    iack1 = 1'b0; stall = 1'b0;
    tick();
    check("wrap_iaddr", iaddr1, 32'h0000_0000);
    check("wrap_ireq", {31'd0, ireq1}, 32'd1);
    check("wrap_valid_clr", {31'd0, valid1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have exactly one clock, Clk, and a synchronous, active-low reset, Clrn, sampled only on the rising edge of Clk.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 Clrn  input  1  synchronous active-low reset.
REQ-005 Stall  input  1  consumer not ready; holds the fetched instruction.
REQ-006 Branch  input  1  take BranchTarget on next accept.
REQ-007 BranchTarget  input  32  branch destination.
REQ-008 Jump  input  1  take JumpTarget on next accept.
REQ-009 JumpTarget  input  32  jump destination.
REQ-010 IReq  output  1  instruction-memory request, registered.
REQ-011 IAddr  output  32  instruction-memory address, equals PC.
REQ-012 IAck  input  1  memory response valid; IData is valid in the same cycle.
REQ-013 IData  input  32  instruction word from memory.
REQ-014 Valid  output  1  Inst/Imm16/Se/PC4 hold a fetched instruction.
REQ-015 Inst  output  32  fetched instruction register.
REQ-016 Imm16  output  16  Inst[15:0], drives the 16-to-32 extender X input.
REQ-017 Se  output  1  extender mode: 1 = sign-extend, 0 = zero-extend.
REQ-018 PC4  output  32  address of the fetched instruction plus 4.

Function
REQ-019 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-020 IDLE: IReq=0; the FSM SHALL move unconditionally to FETCH on the next edge and set IReq=1.
REQ-021 FETCH: IReq=1 and IAddr=PC SHALL stay stable until IAck=1.
REQ-022 FETCH with IAck=1 at an edge: Inst<=IData, PC4<=PC+4, Valid<=1, IReq<=0, and the FSM moves to HOLD.
REQ-023 HOLD with Stall=1: all outputs SHALL hold unchanged and IReq SHALL remain 0.
REQ-024 HOLD with Stall=0 (accept): PC<=next PC, Valid<=0, IReq<=1, and the FSM moves to FETCH.
REQ-025 Next-PC priority: Jump=1 selects JumpTarget; otherwise Branch=1 selects BranchTarget; otherwise PC4.
REQ-026 Next PC SHALL have bits [1:0] forced to 2'b00.
REQ-027 Branch and Jump SHALL be sampled only at an accept edge and ignored in IDLE, FETCH and stalled HOLD.
REQ-028 IAck SHALL be ignored in IDLE and HOLD.
REQ-029 PC+4 SHALL wrap modulo 2^32: PC=32'hFFFF_FFFC gives PC4=32'h0000_0000.
REQ-030 Imm16 SHALL equal Inst[15:0] combinationally.
REQ-031 Se SHALL be 0 when Inst[31:26] is 6'h0C, 6'h0D, 6'h0E or 6'h0F (andi/ori/xori/lui), and 1 otherwise.
REQ-032 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with immediate IAck, then HOLD with Stall=0).

Reset
REQ-033 Clrn=0 at an edge SHALL set PC=RESET_PC, state=IDLE, IReq=0, Valid=0, Inst=0 and PC4=0; IAddr=RESET_PC, Imm16=0 and Se=1 then follow from these registers.
REQ-034 Reset SHALL take priority over every other input, including IAck=1 in FETCH and an accept in HOLD.
REQ-035 Reset asserted mid-transaction SHALL drop IReq on the same edge and discard the pending response.
REQ-036 First request after reset release: IReq=1 with IAddr=RESET_PC, one cycle after the first edge with Clrn=1.

Verification
REQ-037 Reset then IAck=1 when IReq=1 with IData=32'h2008_FFFF -> Valid=1, Inst=32'h2008_FFFF, Imm16=16'hFFFF, Se=1, PC4=32'h0000_0004.
REQ-038 Fetch of IData=32'h3508_8000 (ori) -> Se=0, Imm16=16'h8000; hold Stall=1 for 5 cycles -> outputs unchanged and IReq=0 throughout.
REQ-039 At accept, drive Branch=1, BranchTarget=32'h0000_0042 and Jump=1, JumpTarget=32'h0000_0101 -> next IAddr=32'h0000_0100.
REQ-040 RESET_PC=32'hFFFF_FFFC, fetch completes -> PC4=32'h0000_0000; after accept -> IAddr=32'h0000_0000.
REQ-041 IAck delayed 3 cycles -> IAddr stable and IReq=1 across all waiting cycles; Branch=1 pulsed during FETCH -> ignored, next IAddr=PC4.
REQ-042 Clrn=0 on the same edge as IAck=1 -> Valid=0, IReq=0, Inst=0, and the next request uses IAddr=RESET_PC.
